// File: rtl/icache_tag_ctrl.sv
// Instruction-cache tag RAM sequencer: owns the single RAM port and shares it between
// flush sweeps, refill writes, single-line invalidates and fetch lookups.
module icache_tag_ctrl #(
  parameter bit FLUSH_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_req_i,
  input  logic [31:0] lookup_addr_i,
  output logic        lookup_accept_o,
  output logic        resp_valid_o,
  output logic        hit_o,
  output logic        miss_o,
  input  logic        refill_wr_i,
  input  logic [31:0] refill_addr_i,
  input  logic        inval_i,
  input  logic [31:0] inval_addr_i,
  input  logic        flush_i,
  output logic        flush_busy_o,
  output logic [7:0]  tag_addr_o,
  output logic [19:0] tag_data_o,
  output logic        tag_wr_o,
  input  logic [19:0] tag_data_i
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t      state;
  logic [7:0]  flush_idx;
  logic        pending;
  logic [18:0] req_tag;

  logic grant_refill;
  logic grant_inval;
  logic grant_lookup;

  // Offset bits and the invalidate tag never reach the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{lookup_addr_i[4:0], refill_addr_i[4:0],
                              inval_addr_i[31:13], inval_addr_i[4:0]};

  // Fixed priority in IDLE; a flush request takes the whole cycle with no access.
  always_comb begin
    grant_refill = 1'b0;
    grant_inval  = 1'b0;
    grant_lookup = 1'b0;
    if (!rst && state == ST_IDLE && !flush_i) begin
      if (refill_wr_i)
        grant_refill = 1'b1;
      else if (inval_i)
        grant_inval = 1'b1;
      else if (lookup_req_i)
        grant_lookup = 1'b1;
    end
  end

  always_comb begin
    tag_wr_o   = 1'b0;
    tag_addr_o = lookup_addr_i[12:5];
    tag_data_o = 20'h0;
    if (!rst) begin
      if (state == ST_FLUSH) begin
        tag_wr_o   = 1'b1;
        tag_addr_o = flush_idx;
      end else if (grant_refill) begin
        tag_wr_o   = 1'b1;
        tag_addr_o = refill_addr_i[12:5];
        tag_data_o = {1'b1, refill_addr_i[31:13]};
      end else if (grant_inval) begin
        tag_wr_o   = 1'b1;
        tag_addr_o = inval_addr_i[12:5];
      end
    end
  end

  assign lookup_accept_o = grant_lookup;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FLUSH_ON_RESET ? ST_FLUSH : ST_IDLE;
      flush_idx <= 8'd0;
      pending   <= 1'b0;
      req_tag   <= 19'd0;
    end else begin
      pending <= grant_lookup;
      if (grant_lookup)
        req_tag <= lookup_addr_i[31:13];
      case (state)
        ST_FLUSH: begin
          if (flush_i) begin
            flush_idx <= 8'd0;
          end else begin
            flush_idx <= flush_idx + 8'd1;
            if (flush_idx == 8'hFF)
              state <= ST_IDLE;
          end
        end
        default: begin
          if (flush_i) begin
            state     <= ST_FLUSH;
            flush_idx <= 8'd0;
          end
        end
      endcase
    end
  end

  assign flush_busy_o = (state == ST_FLUSH);

  // RAM data arrives the cycle after accept, so the compare is on the live read port.
  assign resp_valid_o = pending;
  assign hit_o        = pending & tag_data_i[19] & (tag_data_i[18:0] == req_tag);
  assign miss_o       = pending & ~hit_o;

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Directed bench for icache_tag_ctrl with a behavioural read-first 256x20 tag RAM.
module tb_icache_tag_ctrl;

  logic        clk;
  logic        rst;
  logic        lookup_req;
  logic [31:0] lookup_addr;
  logic        lookup_accept;
  logic        resp_valid;
  logic        hit;
  logic        miss;
  logic        refill_wr;
  logic [31:0] refill_addr;
  logic        inval;
  logic [31:0] inval_addr;
  logic        flush;
  logic        flush_busy;
  logic [7:0]  tag_addr;
  logic [19:0] tag_wdata;
  logic        tag_wr;
  logic [19:0] tag_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  icache_tag_ctrl #(.FLUSH_ON_RESET(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_req_i   (lookup_req),
    .lookup_addr_i  (lookup_addr),
    .lookup_accept_o(lookup_accept),
    .resp_valid_o   (resp_valid),
    .hit_o          (hit),
    .miss_o         (miss),
    .refill_wr_i    (refill_wr),
    .refill_addr_i  (refill_addr),
    .inval_i        (inval),
    .inval_addr_i   (inval_addr),
    .flush_i        (flush),
    .flush_busy_o   (flush_busy),
    .tag_addr_o     (tag_addr),
    .tag_data_o     (tag_wdata),
    .tag_wr_o       (tag_wr),
    .tag_data_i     (tag_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-up contents are valid tag-0 entries, so only a real flush makes tag-0 lookups miss.
  logic [19:0] mem [256] = '{default: 20'h80000};
  always @(posedge clk) begin
    tag_rdata <= mem[tag_addr];
    if (tag_wr)
      mem[tag_addr] <= tag_wdata;
  end

  typedef struct {
    logic        refill;
    logic [31:0] raddr;
    logic        inv;
    logic [31:0] iaddr;
    logic        look;
    logic [31:0] laddr;
    logic        fl;
    logic        e_acc;
    logic        e_wr;
    logic [7:0]  e_addr;
    logic [19:0] e_data;
    logic        e_rv;
    logic        e_hit;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic rf, input logic [31:0] ra, input logic iv,
                              input logic [31:0] ia, input logic lk, input logic [31:0] la,
                              input logic fl, input logic acc, input logic wr,
                              input logic [7:0] ad, input logic [19:0] dt,
                              input logic rv, input logic ht);
    vec_t v;
    v.refill = rf; v.raddr = ra; v.inv = iv; v.iaddr = ia;
    v.look = lk; v.laddr = la; v.fl = fl;
    v.e_acc = acc; v.e_wr = wr; v.e_addr = ad; v.e_data = dt;
    v.e_rv = rv; v.e_hit = ht;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lookup_req = 1'b0; lookup_addr = 32'h0;
    refill_wr = 1'b0; refill_addr = 32'h0;
    inval = 1'b0; inval_addr = 32'h0;
    flush = 1'b0;
  endtask

  task automatic flush_sweep(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      #2;
      chk("flush_wr", tag_wr, 1);
      chk("flush_addr", tag_addr, i);
      chk("flush_data", tag_wdata, 0);
      chk("flush_busy", flush_busy, 1);
      chk("flush_acc", lookup_accept, 0);
      chk("flush_rv", resp_valid, 0);
      tick();
    end
    $display("flush sweep idx %0d..%0d done", first, last);
  endtask

  initial begin
    vecs[0]  = mk(1, 32'h0001_2340, 0, 0, 0, 0, 0,            0, 1, 8'h1A, 20'h80009, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 1, 32'h0001_2348, 0,            1, 0, 8'h1A, 20'h0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 1, 32'h0003_2340, 0,            1, 0, 8'h1A, 20'h0, 1, 1);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0,                        0, 0, 8'h00, 20'h0, 1, 0);
    vecs[4]  = mk(1, 32'h0000_E0A0, 1, 32'hC0, 1, 32'h0000_E0A4, 0, 0, 1, 8'h05, 20'h80007, 0, 0);
    vecs[5]  = mk(0, 0, 1, 32'hC0, 1, 32'h0000_E0A4, 0,       0, 1, 8'h06, 20'h0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1, 32'h0000_E0A4, 0,            1, 0, 8'h05, 20'h0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0,                        0, 0, 8'h00, 20'h0, 1, 1);
    vecs[8]  = mk(0, 0, 0, 0, 1, 32'h0001_2348, 0,            1, 0, 8'h1A, 20'h0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 32'h0001_2340, 0, 0, 0,            0, 1, 8'h1A, 20'h0, 1, 1);
    vecs[10] = mk(0, 0, 0, 0, 1, 32'h0001_2348, 0,            1, 0, 8'h1A, 20'h0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0,                        0, 0, 8'h00, 20'h0, 1, 0);
    vecs[12] = mk(1, 32'h0001_2340, 0, 0, 0, 0, 0,            0, 1, 8'h1A, 20'h80009, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 1, 32'h0001_2340, 0,            1, 0, 8'h1A, 20'h0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 32'h0000_00A0, 0,            1, 0, 8'h05, 20'h0, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 1, 32'h0000_E0A0, 0,            1, 0, 8'h05, 20'h0, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 1, 32'h0003_2340, 0,            1, 0, 8'h1A, 20'h0, 1, 1);
    vecs[17] = mk(0, 0, 0, 0, 1, 32'h0000_E0BC, 0,            1, 0, 8'h05, 20'h0, 1, 0);
    vecs[18] = mk(0, 0, 0, 0, 1, 32'h0000_00C0, 0,            1, 0, 8'h06, 20'h0, 1, 1);
    vecs[19] = mk(0, 0, 0, 0, 1, 32'h0001_234C, 0,            1, 0, 8'h1A, 20'h0, 1, 0);
    vecs[20] = mk(0, 0, 0, 0, 1, 32'h0000_0400, 0,            1, 0, 8'h20, 20'h0, 1, 1);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0,                        0, 0, 8'h00, 20'h0, 1, 0);
    vecs[22] = mk(0, 0, 0, 0, 1, 32'h0001_2340, 0,            1, 0, 8'h1A, 20'h0, 0, 0);
    vecs[23] = mk(0, 0, 0, 0, 1, 32'h0001_2340, 1,            0, 0, 8'h1A, 20'h0, 1, 1);

    rst = 1'b1;
    clear_inputs();

    // Reset values
    repeat (2) @(posedge clk);
    #3;
    chk("rst_wr", tag_wr, 0);
    chk("rst_acc", lookup_accept, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_hit", hit, 0);
    chk("rst_miss", miss, 0);
    chk("rst_busy", flush_busy, 1);
    $display("reset state checked");

    // Power-on flush with a lookup held off the whole time
    tick();
    rst = 1'b0;
    lookup_req = 1'b1;
    lookup_addr = 32'h0000_0040;
    flush_sweep(0, 255);
    #2;
    chk("post_flush_busy", flush_busy, 0);
    chk("post_flush_acc", lookup_accept, 1);
    chk("post_flush_wr", tag_wr, 0);
    chk("post_flush_addr", tag_addr, 8'h02);
    tick();
    clear_inputs();
    #2;
    chk("post_flush_rv", resp_valid, 1);
    chk("post_flush_miss", miss, 1);
    chk("post_flush_hit", hit, 0);
    $display("first lookup after flush: rv=%0b miss=%0b", resp_valid, miss);
    tick();

    // Table-driven refill / invalidate / lookup vectors
    for (int i = 0; i < 24; i++) begin
      refill_wr = vecs[i].refill; refill_addr = vecs[i].raddr;
      inval = vecs[i].inv; inval_addr = vecs[i].iaddr;
      lookup_req = vecs[i].look; lookup_addr = vecs[i].laddr;
      flush = vecs[i].fl;
      #2;
      chk($sformatf("v%0d_acc", i), lookup_accept, vecs[i].e_acc);
      chk($sformatf("v%0d_wr", i), tag_wr, vecs[i].e_wr);
      chk($sformatf("v%0d_addr", i), tag_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_data", i), tag_wdata, vecs[i].e_data);
      chk($sformatf("v%0d_rv", i), resp_valid, vecs[i].e_rv);
      chk($sformatf("v%0d_hit", i), hit, vecs[i].e_hit);
      chk($sformatf("v%0d_miss", i), miss, vecs[i].e_rv & ~vecs[i].e_hit);
      $display("vec %0d: acc=%0b wr=%0b addr=%02h data=%05h rv=%0b hit=%0b miss=%0b",
               i, lookup_accept, tag_wr, tag_addr, tag_wdata, resp_valid, hit, miss);
      tick();
    end

    // Flush requested in IDLE, restarted at idx 100
    clear_inputs();
    flush_sweep(0, 99);
    flush = 1'b1;
    #2;
    chk("restart_wr", tag_wr, 1);
    chk("restart_addr", tag_addr, 100);
    chk("restart_busy", flush_busy, 1);
    tick();
    flush = 1'b0;
    flush_sweep(0, 255);
    lookup_req = 1'b1;
    lookup_addr = 32'h0001_2340;
    #2;
    chk("reflush_busy", flush_busy, 0);
    chk("reflush_acc", lookup_accept, 1);
    tick();
    clear_inputs();
    #2;
    chk("reflush_rv", resp_valid, 1);
    chk("reflush_miss", miss, 1);
    $display("refilled line after flush: rv=%0b miss=%0b", resp_valid, miss);
    tick();

    // Reset mid-lookup: one result is live, another lookup is in flight
    lookup_req = 1'b1;
    lookup_addr = 32'h0001_2340;
    tick();
    lookup_addr = 32'h0000_0040;
    #2;
    chk("midlk_rv_before", resp_valid, 1);
    chk("midlk_acc_before", lookup_accept, 1);
    rst = 1'b1;
    #1;
    chk("midlk_rv", resp_valid, 0);
    chk("midlk_miss", miss, 0);
    chk("midlk_hit", hit, 0);
    chk("midlk_acc", lookup_accept, 0);
    chk("midlk_wr", tag_wr, 0);
    chk("midlk_busy", flush_busy, 1);
    $display("reset mid-lookup: rv=%0b acc=%0b busy=%0b", resp_valid, lookup_accept, flush_busy);
    tick();
    clear_inputs();
    rst = 1'b0;

    // Reset mid-flush at idx 50
    flush_sweep(0, 49);
    #2;
    chk("midfl_addr", tag_addr, 50);
    rst = 1'b1;
    #1;
    chk("midfl_wr", tag_wr, 0);
    chk("midfl_busy", flush_busy, 1);
    chk("midfl_rv", resp_valid, 0);
    $display("reset mid-flush at idx %0d", 50);
    tick();
    rst = 1'b0;
    flush_sweep(0, 255);
    #2;
    chk("final_busy", flush_busy, 0);
    chk("final_wr", tag_wr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
